// File: rtl/adder_tree_acc_ctrl.sv
// adder_tree_acc_ctrl
// Reduces a long signed vector, delivered as NUM-element beats, through one
// shared combinational adder tree and accumulates the per-beat sums into a
// single scalar result that is offered on a valid/ready output.
//
// Optional feature macro: ADDER_TREE_ACC_SAT_EN
//   defined   -> an overflowing accumulate clamps to the most positive or most
//                negative ACC_WIDTH value, and later beats continue from there.
//   undefined -> two's-complement wrap.
// In both builds ovf is a sticky flag that is cleared by the next accepted start.

module adder_tree_acc_ctrl #(
    parameter int  IN_WIDTH  = 8,
    parameter int  NUM       = 4,
    parameter int  ACC_WIDTH = 32,
    parameter int  MAX_BEATS = 16,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [CNT_W-1:0]            cfg_beats,
    output logic                        busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM*IN_WIDTH-1:0]     in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_sum,
    output logic                        ovf
);

    // The tree sum of NUM elements needs log2(NUM) growth bits.
    localparam int TREE_W = IN_WIDTH + $clog2(NUM);
    // The tree is laid out as a heap over a power-of-two leaf count; unused
    // leaves are tied to zero so any NUM >= 2 is supported.
    localparam int LEVELS = $clog2(NUM);
    localparam int PAD    = 1 << LEVELS;
    localparam int NODES  = 2 * PAD - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]     beat_target_q, beat_target_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;

    logic [CNT_W-1:0]         cfg_clamped;
    logic                     start_fire;
    logic                     beat_fire;
    logic                     last_beat;

    logic signed [TREE_W-1:0] tree_node [NODES];
    logic signed [TREE_W-1:0] tree_sum;

    logic [ACC_WIDTH:0]       acc_ext;
    logic [ACC_WIDTH:0]       tree_ext;
    logic [ACC_WIDTH:0]       wide_sum;
    logic                     acc_ovf;
    logic [ACC_WIDTH-1:0]     acc_step;

    // Shared adder tree: sign-extend each element to the tree width, then sum
    // pairwise from the leaves up; node 0 is the full beat sum.
    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            tree_node[i] = '0;
        end
        for (int i = 0; i < NUM; i++) begin
            tree_node[PAD - 1 + i] = TREE_W'($signed(in_data[i*IN_WIDTH +: IN_WIDTH]));
        end
        for (int i = PAD - 2; i >= 0; i--) begin
            tree_node[i] = tree_node[2*i + 1] + tree_node[2*i + 2];
        end
        tree_sum = tree_node[0];
    end

    // One-bit-wider accumulate so the true signed result is visible; the two
    // top bits disagreeing means the result left the ACC_WIDTH range.
    always_comb begin
        acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
        tree_ext = (ACC_WIDTH + 1)'(tree_sum);
        wide_sum = acc_ext + tree_ext;
        acc_ovf  = wide_sum[ACC_WIDTH] ^ wide_sum[ACC_WIDTH-1];
`ifdef ADDER_TREE_ACC_SAT_EN
        if (acc_ovf) begin
            if (wide_sum[ACC_WIDTH]) begin
                acc_step = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                acc_step = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            acc_step = wide_sum[ACC_WIDTH-1:0];
        end
`else
        acc_step = wide_sum[ACC_WIDTH-1:0];
`endif
    end

    // Normalise the requested beat count: zero means one beat, and anything
    // above MAX_BEATS is limited to MAX_BEATS.
    always_comb begin
        if (cfg_beats == '0) begin
            cfg_clamped = CNT_W'(1);
        end else if (cfg_beats > CNT_W'(MAX_BEATS)) begin
            cfg_clamped = CNT_W'(MAX_BEATS);
        end else begin
            cfg_clamped = cfg_beats;
        end
    end

    assign last_beat = ((beat_cnt_q + CNT_W'(1)) == beat_target_q);

    // Controller next-state and handshake decode; start is only looked at in
    // IDLE, so pulses while busy are dropped.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        start_fire = 1'b0;
        beat_fire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    start_fire = 1'b1;
                    state_d    = ACC;
                end
            end
            ACC: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    beat_fire = 1'b1;
                    if (last_beat) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Job bookkeeping: a new job clears the accumulator, counter and overflow
    // flag; each accepted beat folds the tree sum in and bumps the counter.
    always_comb begin
        beat_target_d = beat_target_q;
        beat_cnt_d    = beat_cnt_q;
        acc_d         = acc_q;
        ovf_d         = ovf_q;
        if (start_fire) begin
            beat_target_d = cfg_clamped;
            beat_cnt_d    = '0;
            acc_d         = '0;
            ovf_d         = 1'b0;
        end else if (beat_fire) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            acc_d      = acc_step;
            ovf_d      = ovf_q | acc_ovf;
        end
    end

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_target_q <= CNT_W'(1);
            beat_cnt_q    <= '0;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_target_q <= beat_target_d;
            beat_cnt_q    <= beat_cnt_d;
            acc_q         <= acc_d;
            ovf_q         <= ovf_d;
        end
    end

    assign out_sum = acc_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_adder_tree_acc_ctrl.sv
// Testbench for adder_tree_acc_ctrl. Two instances share one stimulus stream:
// a default 32-bit accumulator and a 10-bit accumulator that overflows on the
// saturation/wrap vector. Expected results go into per-instance queues and
// independent monitors compare whenever a result is presented.

module tb_adder_tree_acc_ctrl;

    localparam int IW   = 8;
    localparam int NUM  = 4;
    localparam int MAXB = 16;
    localparam int CW   = 5;

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              start     = 1'b0;
    logic [CW-1:0]     cfg_beats = '0;
    logic              in_valid  = 1'b0;
    logic [NUM*IW-1:0] in_data   = '0;
    logic              out_ready = 1'b0;

    logic        busy_w, in_ready_w, out_valid_w, ovf_w;
    logic [31:0] out_sum_w;
    logic        busy_n, in_ready_n, out_valid_n, ovf_n;
    logic [9:0]  out_sum_n;

    exp_t q_w[$];
    exp_t q_n[$];

    int n_cmp = 0;
    int n_err = 0;

    adder_tree_acc_ctrl #(
        .IN_WIDTH (IW),
        .NUM      (NUM),
        .ACC_WIDTH(32),
        .MAX_BEATS(MAXB)
    ) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_beats(cfg_beats),
        .busy     (busy_w),
        .in_valid (in_valid),
        .in_ready (in_ready_w),
        .in_data  (in_data),
        .out_valid(out_valid_w),
        .out_ready(out_ready),
        .out_sum  (out_sum_w),
        .ovf      (ovf_w)
    );

    adder_tree_acc_ctrl #(
        .IN_WIDTH (IW),
        .NUM      (NUM),
        .ACC_WIDTH(10),
        .MAX_BEATS(MAXB)
    ) dut_n (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_beats(cfg_beats),
        .busy     (busy_n),
        .in_valid (in_valid),
        .in_ready (in_ready_n),
        .in_data  (in_data),
        .out_valid(out_valid_n),
        .out_ready(out_ready),
        .out_sum  (out_sum_n),
        .ovf      (ovf_n)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic pushExp(input int sw, input logic ow, input int sn, input logic on);
        exp_t e;
        e.sum = sw;
        e.ovf = ow;
        q_w.push_back(e);
        e.sum = sn;
        e.ovf = on;
        q_n.push_back(e);
    endtask

    // Monitor for the 32-bit instance: result must match the queue head while
    // presented, and is retired on the handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid_w) begin
            if (q_w.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL w_unexpected_result: got sum 0x%0h, expected no result", out_sum_w);
            end else begin
                checkOutput("w_out_sum", out_sum_w, q_w[0].sum);
                checkOutput("w_ovf", {31'b0, ovf_w}, {31'b0, q_w[0].ovf});
                checkOutput("w_in_ready_in_out", {31'b0, in_ready_w}, 32'd0);
                if (out_ready) void'(q_w.pop_front());
            end
        end
    end

    // Monitor for the 10-bit instance.
    always @(negedge clk) begin
        if (rst_n && out_valid_n) begin
            if (q_n.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL n_unexpected_result: got sum 0x%0h, expected no result", out_sum_n);
            end else begin
                checkOutput("n_out_sum", {22'b0, out_sum_n}, {22'b0, q_n[0].sum[9:0]});
                checkOutput("n_ovf", {31'b0, ovf_n}, {31'b0, q_n[0].ovf});
                if (out_ready) void'(q_n.pop_front());
            end
        end
    end

    task automatic startJob(input int beats);
        start     = 1'b1;
        cfg_beats = beats[CW-1:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", {31'b0, busy_w}, 32'd1);
        checkOutput("in_ready_after_start", {31'b0, in_ready_n}, 32'd1);
    endtask

    // Drive one beat and check out_valid just after the accepting edge.
    task automatic applyStimulus(input int a, input int b, input int c, input int d, input logic last);
        in_valid = 1'b1;
        in_data  = pk(a, b, c, d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        checkOutput("w_out_valid_after_beat", {31'b0, out_valid_w}, {31'b0, last});
        checkOutput("n_out_valid_after_beat", {31'b0, out_valid_n}, {31'b0, last});
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        in_data  = $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic postHandshake();
        @(posedge clk);
        #1;
        checkOutput("busy_after_result", {31'b0, busy_w}, 32'd0);
        checkOutput("out_valid_after_result", {31'b0, out_valid_n}, 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, {30'b0, busy_w, busy_n}, 32'd0);
        checkOutput({tag, "_in_ready"}, {30'b0, in_ready_w, in_ready_n}, 32'd0);
        checkOutput({tag, "_out_valid"}, {30'b0, out_valid_w, out_valid_n}, 32'd0);
        checkOutput({tag, "_ovf"}, {30'b0, ovf_w, ovf_n}, 32'd0);
        checkOutput({tag, "_w_out_sum"}, out_sum_w, 32'd0);
        checkOutput({tag, "_n_out_sum"}, {22'b0, out_sum_n}, 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed job sequence.
    initial begin
        int sat_n;
        int drain;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic sum: 10 + 26 = 36.
        out_ready = 1'b1;
        pushExp(36, 1'b0, 36, 1'b0);
        startJob(2);
        applyStimulus(1, 2, 3, 4, 1'b0);
        applyStimulus(5, 6, 7, 8, 1'b1);
        postHandshake();

        // Signed: three beats of -4.
        pushExp(-12, 1'b0, -12, 1'b0);
        startJob(3);
        applyStimulus(-1, -1, -1, -1, 1'b0);
        applyStimulus(-1, -1, -1, -1, 1'b0);
        applyStimulus(-1, -1, -1, -1, 1'b1);
        postHandshake();

        // Backpressure: 4 + 8 - 12 + 60 = 60, bubbles, stalled result, stray starts.
        out_ready = 1'b0;
        pushExp(60, 1'b0, 60, 1'b0);
        startJob(4);
        applyStimulus(1, 1, 1, 1, 1'b0);
        start     = 1'b1;
        cfg_beats = 5'd1;
        bubble();
        start = 1'b0;
        checkOutput("busy_start_in_acc", {31'b0, busy_w}, 32'd1);
        applyStimulus(2, 2, 2, 2, 1'b0);
        bubble();
        applyStimulus(-3, -3, -3, -3, 1'b0);
        bubble();
        applyStimulus(100, -50, 3, 7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            checkOutput("stall_out_valid", {31'b0, out_valid_w}, 32'd1);
            checkOutput("stall_in_ready", {31'b0, in_ready_n}, 32'd0);
        end
        out_ready = 1'b1;
        postHandshake();
        @(posedge clk);
        #1;
        checkOutput("no_restart_after_stall", {31'b0, busy_n}, 32'd0);

        // Overflow: 508 + 508 = 1016 exceeds the 10-bit range.
`ifdef ADDER_TREE_ACC_SAT_EN
        sat_n = 511;
`else
        sat_n = -8;
`endif
        pushExp(1016, 1'b0, sat_n, 1'b1);
        startJob(2);
        applyStimulus(127, 127, 127, 127, 1'b0);
        applyStimulus(127, 127, 127, 127, 1'b1);
        postHandshake();
        checkOutput("n_ovf_sticky_idle", {31'b0, ovf_n}, 32'd1);

        // Reset in the middle of a job; the next start also clears ovf.
        startJob(3);
        checkOutput("n_ovf_cleared_on_start", {31'b0, ovf_n}, 32'd0);
        applyStimulus(1, 1, 1, 1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midjob_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pushExp(100, 1'b0, 100, 1'b0);
        startJob(1);
        applyStimulus(10, 20, 30, 40, 1'b1);
        postHandshake();

        // cfg_beats = 0 behaves as a single beat.
        pushExp(8, 1'b0, 8, 1'b0);
        startJob(0);
        applyStimulus(2, 2, 2, 2, 1'b1);
        postHandshake();

        // cfg_beats above MAX_BEATS runs exactly MAX_BEATS beats.
        pushExp(16, 1'b0, 16, 1'b0);
        startJob(31);
        for (int i = 0; i < MAXB; i++) begin
            applyStimulus(1, 0, 0, 0, (i == MAXB - 1));
        end
        postHandshake();

        drain = 0;
        while ((q_w.size() != 0 || q_n.size() != 0) && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        checkOutput("w_results_outstanding", q_w.size(), 32'd0);
        checkOutput("n_results_outstanding", q_n.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_tree_acc_ctrl.md
# adder_tree_acc_ctrl

Sequencing controller that reduces a long signed vector through one shared combinational adder tree. The vector arrives as a stream of NUM-element beats. The block accepts a job, steps the tree across cfg_beats input beats, accumulates the per-beat tree sums, and presents one scalar result with a valid/ready handshake. It sits between the activation buffer and the post-processing stage of the NN datapath.

## Interface
- IN_WIDTH, 8: width of one signed element.
- NUM, 4: elements per beat (adder-tree fan-in), ≥2.
- ACC_WIDTH, 32: accumulator/result width; must be ≥ IN_WIDTH+$clog2(NUM).
- MAX_BEATS, 16: maximum beats per job.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- cfg_beats  in  $clog2(MAX_BEATS+1)  beats in the job; latched on the accepted start.
- busy  out  1  high in ACC and OUT.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat ready.
- in_data  in  NUM*IN_WIDTH  NUM packed signed elements; element 0 in [IN_WIDTH-1:0].
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- out_sum  out  ACC_WIDTH, signed  accumulated result.
- ovf  out  1  sticky overflow flag for the current or last job.

## Operation
- FSM states are IDLE, ACC, OUT.
- IDLE:
  - start=1 → latch cfg_beats into beat_target; clear acc, beat counter and ovf; move to ACC.
  - cfg_beats=0 is treated as 1; cfg_beats>MAX_BEATS is clamped to MAX_BEATS.
- ACC:
  - in_ready=1.
  - Each handshake (in_valid&in_ready): acc ← acc + sext(tree_sum); counter increments.
  - tree_sum is the signed sum of the NUM elements, width IN_WIDTH+$clog2(NUM), sign-extended to ACC_WIDTH.
  - When the accepted beat is beat number beat_target → OUT.
- OUT:
  - out_valid=1; out_sum=acc, held stable; in_ready=0.
  - out_valid&out_ready → IDLE.
- start is ignored while busy.
- Arithmetic wraps modulo 2^ACC_WIDTH by default.
- ovf is set on any accumulate whose true signed result is outside the ACC_WIDTH range. It stays set until the next accepted start.
- Reset values: busy, in_ready, out_valid and ovf = 0; out_sum = 0; state = IDLE.
- Async reset mid-job abandons the job immediately, with no partial output.

## Timing
- Throughput: one beat per cycle in ACC; the tree path is combinational from in_data to the acc register.
- start is accepted at edge t0: busy=1 and in_ready=1 from t0+.
- The final beat is accepted at edge tk: acc is updated and out_valid=1 from tk+ (1-cycle latency).
- A result handshake at edge tr gives out_valid=0 and busy=0 from tr+. A new start is accepted no earlier than the edge after tr.
- in_valid low in ACC inserts bubbles; acc and the counter hold.
- out_ready low in OUT stalls indefinitely; out_sum and ovf are stable.
- in_data is don't-care when in_valid=0 or in_ready=0.

## Configuration
- ADDER_TREE_ACC_SAT_EN defined:
  - An overflowing accumulate clamps to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) according to the sign of the true result.
  - Subsequent beats continue from the clamped value.
  - ovf is still set.
- ADDER_TREE_ACC_SAT_EN undefined: two's-complement wrap; ovf set on overflow.

## Test plan
- Basic sum: defaults, cfg_beats=2, beats {1,2,3,4} then {5,6,7,8}, out_ready=1 → out_valid one cycle after second beat, out_sum=36, ovf=0, busy low the cycle after the handshake.
- Signed: cfg_beats=3, three beats of {-1,-1,-1,-1} → out_sum=-12.
- Backpressure: cfg_beats=4, in_valid toggled every other cycle, out_ready low for 5 cycles in OUT, start pulsed during ACC and OUT → out_sum=correct total and stable, in_ready=0 throughout OUT, start ignored, exactly one result.
- Overflow: ACC_WIDTH=10, cfg_beats=2, beats of {127,127,127,127} → without the macro out_sum=-8 (1016 wrapped), ovf=1; with ADDER_TREE_ACC_SAT_EN out_sum=511, ovf=1; ovf cleared at the next start.
- Reset mid-job: rst_n low for 1 cycle after 1 of 3 beats → all outputs 0 immediately. Then start with cfg_beats=1 and beat {10,20,30,40} → out_sum=100, ovf=0.
- Edge config: cfg_beats=0 with one beat {2,2,2,2} → out_sum=8 after exactly one beat.
